mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests take priority over instruction fetches,
// with a bounded wait so a stalled or faulting RAM can never deadlock a requester.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);

  // RAM status encoding: FREE=00, BUSY=01, ACCESS=10, ERROR=11
  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  typedef enum logic [1:0] {IDLE, DSERV, ISERV, RESP} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        req_wr;
  logic [4:0]  wait_next;
  logic        access;
  logic        abort;

  // An aborted read returns zero rather than whatever the RAM bus holds.
  function automatic logic [31:0] fill_load(input logic ok, input logic [31:0] word);
    return ok ? word : 32'h0;
  endfunction

  assign access    = (ramstate == RAM_ACCESS);
  assign wait_next = {1'b0, wait_cnt} + 5'd1;
  // ACCESS wins over a coincident timeout, so abort is only checked without it.
  assign abort     = !access && ((ramstate == RAM_ERROR) || (wait_next == 5'(TIMEOUT)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      req_wr   <= 1'b0;
      iload    <= 32'h0;
      dload    <= 32'h0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= 32'h0;
      ramstore <= 32'h0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dREN || dWEN) begin
            state    <= DSERV;
            req_wr   <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
            wait_cnt <= 4'd0;
          end else if (iREN) begin
            state    <= ISERV;
            req_wr   <= 1'b0;
            ramaddr  <= iaddr;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
            wait_cnt <= 4'd0;
          end
        end
        DSERV, ISERV: begin
          if (!access) wait_cnt <= wait_next[3:0];
          if (access || abort) begin
            state  <= RESP;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (state == ISERV) begin
              iload <= fill_load(access, ramload);
              ihit  <= 1'b1;
            end else begin
              dhit <= 1'b1;
              if (!req_wr) dload <= fill_load(access, ramload);
            end
            if (abort) mem_err <= 1'b1;
          end
        end
        RESP: begin
          ihit  <= 1'b0;
          dhit  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a scripted RAM responder drives each transaction and a
// hit monitor pops expected load/error values from a scoreboard queue.
module tb_mem_arbiter;

  localparam int TIMEOUT = 15;
  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, mem_err;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        isd;
    logic [31:0] dl;
    logic [31:0] il;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_dload = 32'h0;
  logic [31:0] exp_iload = 32'h0;
  logic        exp_err   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (ihit || dhit) begin
      if (sb.size() == 0) begin
        chk("unexpected_hit", {30'h0, dhit, ihit}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hit_kind", {30'h0, dhit, ihit}, e.isd ? 32'h2 : 32'h1);
        chk("dload", dload, e.dl);
        chk("iload", iload, e.il);
        chk("mem_err", {31'h0, mem_err}, {31'h0, e.err});
      end
    end
  end

  // One transaction: request at an IDLE negedge, RAM answers BUSY nbusy times,
  // then ACCESS (or ERROR when err is set).
  task automatic txn(input logic isd, input logic wr, input logic both, input logic keep_i,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int nbusy, input logic err);
    int   en;
    int   en_exp;
    logic timed_out;
    logic abort;
    logic done;
    exp_t e;
    timed_out = !err && (nbusy >= TIMEOUT);
    abort     = err || timed_out;
    en_exp    = timed_out ? TIMEOUT : nbusy + 1;

    @(negedge CLK);
    if (isd) begin
      dWEN   = wr;
      dREN   = !wr || both;
      daddr  = addr;
      dstore = wdata;
      iREN   = keep_i;
    end else begin
      iREN  = 1'b1;
      iaddr = addr;
    end
    ramstate = BUSY;
    if (isd && !wr) exp_dload = abort ? 32'h0 : rdata;
    if (!isd)       exp_iload = abort ? 32'h0 : rdata;
    exp_err = exp_err | abort;
    e.isd = isd; e.dl = exp_dload; e.il = exp_iload; e.err = exp_err;
    sb.push_back(e);

    @(posedge CLK);
    #1;
    dREN = 1'b0; dWEN = 1'b0;
    if (!keep_i) iREN = 1'b0;
    daddr = ~addr; dstore = ~wdata;
    if (!keep_i) iaddr = ~addr;

    en = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) begin
        en++;
        chk("ramaddr", ramaddr, addr);
        chk("ramWEN", {31'h0, ramWEN}, {31'h0, wr});
        chk("ramREN", {31'h0, ramREN}, {31'h0, !wr});
        if (wr) chk("ramstore", ramstore, wdata);
        ramload  = rdata;
        ramstate = (en <= nbusy) ? BUSY : (err ? ERROR : ACCESS);
      end else begin
        done = 1'b1;
        chk("hit_at_resp", {30'h0, dhit, ihit}, isd ? 32'h2 : 32'h1);
        chk("en_cycles", en, en_exp);
        ramstate = FREE;
        ramload  = $urandom;
      end
    end
    chk("txn_done", {31'h0, done}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
    ramload = 32'h0; ramstate = FREE;
    #13;
    chk("rst_ramREN", {31'h0, ramREN}, 32'h0);
    chk("rst_ramWEN", {31'h0, ramWEN}, 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_loads", iload | dload, 32'h0);
    chk("rst_hits", {30'h0, dhit, ihit}, 32'h0);
    chk("rst_mem_err", {31'h0, mem_err}, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;

    // fetch with two BUSY cycles
    txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h2401_0005, 2, 1'b0);
    // read to give dload a value, then a write that must not touch it
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1, 1'b0);
    txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'hDEAD_BEEF, 32'h5555_5555, 0, 1'b0);
    // dREN and dWEN together is a write
    txn(1'b1, 1'b1, 1'b1, 1'b0, 32'h84, 32'h0BAD_0001, 32'h6666_6666, 1, 1'b0);
    // data beats a simultaneous fetch; the held fetch follows
    txn(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
    txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0BAD_CAFE, 0, 1'b0);
    // ACCESS on the cycle the counter would expire: no error
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h180, 32'h0, 32'h1357_9BDF, TIMEOUT - 1, 1'b0);
    // RAM stuck BUSY: timeout
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h7777_7777, 100, 1'b0);
    // later good transactions keep mem_err set
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h24, 32'h0, 32'hA5A5_0001, 0, 1'b0);
    txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h48, 32'h0, 32'h1111_2222, 1, 1'b0);
    // ERROR response on a fetch
    txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h9999_9999, 0, 1'b1);

    // reset in the middle of a fetch
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h3C0; ramstate = BUSY;
    @(posedge CLK);
    #1 iREN = 1'b0;
    @(negedge CLK);
    chk("pre_rst_ramREN", {31'h0, ramREN}, 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_ramREN", {31'h0, ramREN}, 32'h0);
    chk("mid_rst_ramaddr", ramaddr, 32'h0);
    chk("mid_rst_ramstore", ramstore, 32'h0);
    chk("mid_rst_dload", dload, 32'h0);
    chk("mid_rst_hits", {30'h0, dhit, ihit}, 32'h0);
    chk("mid_rst_mem_err", {31'h0, mem_err}, 32'h0);
    exp_dload = 32'h0; exp_iload = 32'h0; exp_err = 1'b0;
    ramstate = FREE;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("post_rst_idle", {30'h0, ihit, ramREN}, 32'h0);
    end
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h28, 32'h0, 32'h0F0F_F0F0, 1, 1'b0);

    @(negedge CLK);
    chk("sb_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
